// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU results and FIFO-buffered load responses onto the register file write port, with a pending-write scoreboard
//   ports: clk, reset (sync, active-high); alu_valid/alu_dest/alu_value -> alu_stall;
//   mem_valid/mem_dest/mem_value -> mem_ready; issue_valid/issue_dest;
//   write_enabled/destination_source/writing_value (registered); pending_mask
module wb_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_LENGTH   = 32,
  parameter int REG_LENGTH   = 5,
  parameter int REGF_LENGTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [REG_LENGTH-1:0]  alu_dest,
  input  logic [MAX_LENGTH-1:0]  alu_value,
  output logic                   alu_stall,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [REG_LENGTH-1:0]  mem_dest,
  input  logic [MAX_LENGTH-1:0]  mem_value,
  input  logic                   issue_valid,
  input  logic [REG_LENGTH-1:0]  issue_dest,
  output logic                   write_enabled,
  output logic [REG_LENGTH-1:0]  destination_source,
  output logic [MAX_LENGTH-1:0]  writing_value,
  output logic [REGF_LENGTH-1:0] pending_mask
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [REG_LENGTH-1:0]  fd [FIFO_DEPTH];
  logic [MAX_LENGTH-1:0]  fv [FIFO_DEPTH];
  logic [AW:0]            rp, wp;
  logic [CW-1:0]          cnt;
  logic                   empty, push, pop, wr;
  logic [REG_LENGTH-1:0]  wd;
  logic [MAX_LENGTH-1:0]  wv;
  logic [REGF_LENGTH-1:0] pm_next;
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty     = rp == wp;
    mem_ready = !(wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0]);
    alu_stall = cnt == CW'(STARVE_LIMIT);
    pop       = !empty && (alu_stall || !alu_valid);
    push      = mem_valid && mem_ready;
    wr        = pop || alu_valid;
    wd        = pop ? fd[rp[AW-1:0]] : alu_dest;
    wv        = pop ? fv[rp[AW-1:0]] : alu_value;
    pm_next   = (pending_mask & ~(wr ? REGF_LENGTH'(1) << wd : '0))
              | (issue_valid ? REGF_LENGTH'(1) << issue_dest : '0);
    pm_next[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (push) begin
      fd[wp[AW-1:0]] <= mem_dest;
      fv[wp[AW-1:0]] <= mem_value;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      rp                 <= '0;
      wp                 <= '0;
      cnt                <= '0;
      write_enabled      <= 1'b0;
      destination_source <= '0;
      writing_value      <= '0;
      pending_mask       <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt           <= (empty || pop) ? '0 : alu_stall ? cnt : cnt + CW'(1);
      write_enabled <= wr && wd != '0;
      if (wr) begin
        destination_source <= wd;
        writing_value      <= wv;
      end
      pending_mask <= pm_next;
    end
  end
endmodule
